// File: rtl/spi_slave_core_if.sv
// Bus bundle between the SPI slave core and its master/register side:
// SPI pins, TX holding-buffer handshake, RX strobe and status strobes.
interface spi_slave_core_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  sclk;
    logic                  ss_n;
    logic                  mosi;
    logic                  miso;
    logic                  miso_oe;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  underrun;
    logic                  frame_abort;
    logic                  busy;

    modport slave (
        input  sclk, ss_n, mosi, tx_data, tx_valid,
        output miso, miso_oe, tx_ready, rx_data, rx_valid, underrun, frame_abort, busy
    );

    modport master (
        output sclk, ss_n, mosi, tx_data, tx_valid,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid, underrun, frame_abort, busy
    );
endinterface

// File: rtl/spi_slave_core.sv
// SPI slave fully inside clk: oversampled sclk/ss_n/mosi, any CPOL/CPHA, width and bit order,
// with a one-word TX holding buffer and single-cycle RX/status strobes.
//
// state     | meaning
// ST_IDLE   | deselected, miso tri-stated (miso_oe=0), sclk edges ignored
// ST_ACTIVE | selected, shifting words; ss_n rise returns to ST_IDLE
module spi_slave_core #(
    parameter int DATA_WIDTH  = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_slave_core_if.slave  bus
);
    localparam int                CNT_W     = $clog2(DATA_WIDTH);
    localparam logic              SCLK_IDLE = (CPOL != 0);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   ss_prev_q, ss_prev_d;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]  tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0]  rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
    logic [DATA_WIDTH-1:0]  buf_data_q, buf_data_d;
    logic                   buf_full_q, buf_full_d;
    logic                   load_pend_q, load_pend_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   underrun_q, underrun_d;
    logic                   frame_abort_q, frame_abort_d;
    logic                   miso_q, miso_d;
    logic                   miso_oe_q, miso_oe_d;
    logic                   busy_q, busy_d;

    logic                   sclk_s, ss_s, mosi_s;
    logic                   lead_edge, trail_edge, sample_edge, shift_edge;
    logic                   ss_fall, ss_rise, tx_accept, do_load;
    logic [DATA_WIDTH-1:0]  rx_next, tx_next, load_word;

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[DATA_WIDTH-1] : w[0];
    endfunction

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s        = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign lead_edge   = (sclk_s != sclk_prev_q) && (sclk_s != SCLK_IDLE);
    assign trail_edge  = (sclk_s != sclk_prev_q) && (sclk_s == SCLK_IDLE);
    assign sample_edge = (CPHA == 0) ? lead_edge : trail_edge;
    assign shift_edge  = (CPHA == 0) ? trail_edge : lead_edge;
    assign ss_fall     = ss_prev_q && !ss_s;
    assign ss_rise     = !ss_prev_q && ss_s;
    assign tx_accept   = bus.tx_valid && !buf_full_q;
    assign rx_next     = (MSB_FIRST != 0) ? {rx_shift_q[DATA_WIDTH-2:0], mosi_s}
                                          : {mosi_s, rx_shift_q[DATA_WIDTH-1:1]};
    assign tx_next     = (MSB_FIRST != 0) ? (tx_shift_q << 1) : (tx_shift_q >> 1);

    always_comb begin
        sclk_sync_d   = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
        ss_sync_d     = {ss_sync_q[SYNC_STAGES-2:0], bus.ss_n};
        mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
        sclk_prev_d   = sclk_s;
        ss_prev_d     = ss_s;
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        tx_shift_d    = tx_shift_q;
        rx_shift_d    = rx_shift_q;
        rx_data_d     = rx_data_q;
        buf_data_d    = buf_data_q;
        buf_full_d    = buf_full_q;
        load_pend_d   = load_pend_q;
        rx_valid_d    = 1'b0;
        underrun_d    = 1'b0;
        frame_abort_d = 1'b0;
        miso_d        = miso_q;
        miso_oe_d     = miso_oe_q;
        busy_d        = busy_q;
        do_load       = 1'b0;
        load_word     = '0;

        case (state_q)
            ST_IDLE: begin
                if (ss_fall) begin
                    state_d     = ST_ACTIVE;
                    busy_d      = 1'b1;
                    miso_oe_d   = 1'b1;
                    bit_cnt_d   = '0;
                    load_pend_d = 1'b0;
                    do_load     = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (sample_edge) begin
                    rx_shift_d = rx_next;
                    if (bit_cnt_q == LAST_BIT) begin
                        rx_data_d  = rx_next;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                        // Next word goes out at the next shift point: now for CPHA=0,
                        // at the following leading edge for CPHA=1.
                        if (CPHA == 0) do_load = 1'b1;
                        else           load_pend_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (shift_edge) begin
                    if (bit_cnt_q != '0) begin
                        tx_shift_d = tx_next;
                        miso_d     = first_bit(tx_next);
                    end else if (load_pend_q) begin
                        do_load     = 1'b1;
                        load_pend_d = 1'b0;
                    end
                end
                // A word completing in the same cycle as deselect leaves bit_cnt_d at 0: no abort.
                if (ss_rise) begin
                    state_d       = ST_IDLE;
                    busy_d        = 1'b0;
                    miso_oe_d     = 1'b0;
                    miso_d        = 1'b0;
                    load_pend_d   = 1'b0;
                    frame_abort_d = (bit_cnt_d != '0);
                    bit_cnt_d     = '0;
                    do_load       = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (do_load) begin
            if (buf_full_q) begin
                load_word  = buf_data_q;
                buf_full_d = 1'b0;
            end else if (tx_accept) begin
                load_word = bus.tx_data;
            end else begin
                underrun_d = 1'b1;
            end
            tx_shift_d = load_word;
            miso_d     = first_bit(load_word);
        end

        if (tx_accept && !do_load) begin
            buf_data_d = bus.tx_data;
            buf_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q   <= {SYNC_STAGES{SCLK_IDLE}};
            ss_sync_q     <= '1;
            mosi_sync_q   <= '0;
            sclk_prev_q   <= SCLK_IDLE;
            ss_prev_q     <= 1'b1;
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            tx_shift_q    <= '0;
            rx_shift_q    <= '0;
            rx_data_q     <= '0;
            buf_data_q    <= '0;
            buf_full_q    <= 1'b0;
            load_pend_q   <= 1'b0;
            rx_valid_q    <= 1'b0;
            underrun_q    <= 1'b0;
            frame_abort_q <= 1'b0;
            miso_q        <= 1'b0;
            miso_oe_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            sclk_sync_q   <= sclk_sync_d;
            ss_sync_q     <= ss_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            sclk_prev_q   <= sclk_prev_d;
            ss_prev_q     <= ss_prev_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            tx_shift_q    <= tx_shift_d;
            rx_shift_q    <= rx_shift_d;
            rx_data_q     <= rx_data_d;
            buf_data_q    <= buf_data_d;
            buf_full_q    <= buf_full_d;
            load_pend_q   <= load_pend_d;
            rx_valid_q    <= rx_valid_d;
            underrun_q    <= underrun_d;
            frame_abort_q <= frame_abort_d;
            miso_q        <= miso_d;
            miso_oe_q     <= miso_oe_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.miso        = miso_q;
    assign bus.miso_oe     = miso_oe_q;
    assign bus.tx_ready    = !buf_full_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.underrun    = underrun_q;
    assign bus.frame_abort = frame_abort_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: five instances (modes 0-3 MSB-first, mode 0 LSB-first) driven by one
// behavioural SPI master; expectations come from a word-level model of loads, strobes and data.
module tb_spi_slave_core;
    localparam int NCFG = 5;
    localparam int DW   = 8;
    localparam int H    = 8;
    localparam int CPOL_A [NCFG] = '{0, 0, 1, 1, 0};
    localparam int CPHA_A [NCFG] = '{0, 1, 0, 1, 0};
    localparam int MSB_A  [NCFG] = '{1, 1, 1, 1, 0};

    logic clk = 1'b0;
    logic rst_n;
    logic sclk_base, mosi;
    logic [NCFG-1:0]         ss_n_a, tx_valid_a;
    logic [NCFG-1:0][DW-1:0] tx_data_a, rx_data_a;
    logic [NCFG-1:0]         miso_a, oe_a, tx_ready_a, rx_valid_a, und_a, abort_a, busy_a;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        spi_slave_core_if #(.DATA_WIDTH(DW)) bus ();
        assign bus.sclk     = sclk_base ^ (CPOL_A[g] != 0);
        assign bus.ss_n     = ss_n_a[g];
        assign bus.mosi     = mosi;
        assign bus.tx_data  = tx_data_a[g];
        assign bus.tx_valid = tx_valid_a[g];
        assign miso_a[g]     = bus.miso;
        assign oe_a[g]       = bus.miso_oe;
        assign tx_ready_a[g] = bus.tx_ready;
        assign rx_data_a[g]  = bus.rx_data;
        assign rx_valid_a[g] = bus.rx_valid;
        assign und_a[g]      = bus.underrun;
        assign abort_a[g]    = bus.frame_abort;
        assign busy_a[g]     = bus.busy;
        spi_slave_core #(
            .DATA_WIDTH(DW), .CPOL(CPOL_A[g]), .CPHA(CPHA_A[g]),
            .MSB_FIRST(MSB_A[g]), .SYNC_STAGES(2)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    int          sel      = 0;
    logic [7:0]  feed [$];
    int          feed_rd, model_ptr;
    logic        acc_pend;
    int          rx_cnt, und_cnt, abort_cnt;
    logic [7:0]  exp_rx;
    logic [7:0]  mosi_w [4];
    logic [7:0]  cap_w  [4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: account for the previous handshake, count strobes, drive the TX feeder.
    task automatic tick();
        @(negedge clk);
        if (acc_pend) feed_rd++;
        if (rx_valid_a[sel]) rx_cnt++;
        if (und_a[sel])      und_cnt++;
        if (abort_a[sel])    abort_cnt++;
        tx_valid_a = '0;
        if (rst_n && feed_rd < feed.size()) begin
            tx_valid_a[sel] = 1'b1;
            tx_data_a[sel]  = feed[feed_rd];
        end
        acc_pend = tx_valid_a[sel] & tx_ready_a[sel];
    endtask

    task automatic wait_t(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        acc_pend   = 1'b0;
        tx_valid_a = '0;
        ss_n_a     = '1;
        sclk_base  = 1'b0;
        mosi       = 1'b0;
        feed.delete();
        feed_rd    = 0;
        model_ptr  = 0;
        exp_rx     = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_t(4);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_miso"},     32'(miso_a[sel]),     0);
        chk({tag, "_oe"},       32'(oe_a[sel]),       0);
        chk({tag, "_tx_ready"}, 32'(tx_ready_a[sel]), 1);
        chk({tag, "_rx_data"},  32'(rx_data_a[sel]),  0);
        chk({tag, "_rx_valid"}, 32'(rx_valid_a[sel]), 0);
        chk({tag, "_underrun"}, 32'(und_a[sel]),      0);
        chk({tag, "_abort"},    32'(abort_a[sel]),    0);
        chk({tag, "_busy"},     32'(busy_a[sel]),     0);
    endtask

    task automatic spi_frame(input string tag, input int nbits, input bit raise);
        int  cpha = CPHA_A[sel];
        bit  msb  = (MSB_A[sel] != 0);
        logic b, c;
        for (int j = 0; j < 4; j++) cap_w[j] = '0;
        ss_n_a[sel] = 1'b0;
        wait_t(H);
        for (int i = 0; i < nbits; i++) begin
            int j = i / DW;
            int k = i % DW;
            b = msb ? mosi_w[j][7-k] : mosi_w[j][k];
            if (cpha == 0) begin
                mosi = b;
                wait_t(H);
                c = miso_a[sel];
                sclk_base = 1'b1;
                wait_t(H);
                sclk_base = 1'b0;
            end else begin
                sclk_base = 1'b1;
                mosi = b;
                wait_t(H);
                c = miso_a[sel];
                sclk_base = 1'b0;
                wait_t(H);
            end
            if (msb) cap_w[j][7-k] = c;
            else     cap_w[j][k]   = c;
            if (i == 1) begin
                chk({tag, "_busy_mid"}, 32'(busy_a[sel]), 1);
                chk({tag, "_oe_mid"},   32'(oe_a[sel]),   1);
            end
        end
        wait_t(H);
        if (raise) begin
            ss_n_a[sel] = 1'b1;
            wait_t(2 * H);
        end
    endtask

    // Word-level model: each load takes the next queued TX word in order, or 0 with an underrun.
    task automatic check_frame(input string tag, input int nbits);
        int full = nbits / DW;
        int part = nbits % DW;
        int loads;
        int exp_und = 0;
        logic [7:0] ew;
        if (CPHA_A[sel] == 0) loads = 1 + full;
        else                  loads = (nbits == 0) ? 1 : 1 + (nbits - 1) / DW;
        for (int l = 0; l < loads; l++) begin
            if (model_ptr < feed.size()) begin
                ew = feed[model_ptr];
                model_ptr++;
            end else begin
                ew = '0;
                exp_und++;
            end
            if (l < full) chk($sformatf("%s_miso_w%0d", tag, l), 32'(cap_w[l]), 32'(ew));
        end
        if (full > 0) exp_rx = mosi_w[full-1];
        chk({tag, "_rx_cnt"},   rx_cnt,                 full);
        chk({tag, "_rx_data"},  32'(rx_data_a[sel]),    32'(exp_rx));
        chk({tag, "_underrun"}, und_cnt,                exp_und);
        chk({tag, "_abort"},    abort_cnt,              (part != 0) ? 1 : 0);
        chk({tag, "_busy_end"}, 32'(busy_a[sel]),       0);
        chk({tag, "_oe_end"},   32'(oe_a[sel]),         0);
        chk({tag, "_miso_end"}, 32'(miso_a[sel]),       0);
    endtask

    task automatic run_frame(input string tag, input int nbits);
        rx_cnt = 0; und_cnt = 0; abort_cnt = 0;
        spi_frame(tag, nbits, 1'b1);
        check_frame(tag, nbits);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string t;
        rst_n = 1'b0;
        do_reset();
        for (int c = 0; c < NCFG; c++) begin
            sel = c;
            do_reset();
            check_reset($sformatf("c%0d_rst", c));

            // Directed single word.
            feed.push_back((c == 0) ? 8'hA5 : 8'h0F);
            mosi_w[0] = (c == 0) ? 8'h3C : 8'h81;
            run_frame($sformatf("c%0d_dir", c), 8);

            // Three-word burst; a fourth word covers the speculative load after the last word.
            do_reset();
            feed.push_back(8'h11); feed.push_back(8'h22);
            feed.push_back(8'h33); feed.push_back(8'h44);
            mosi_w[0] = 8'h11; mosi_w[1] = 8'h22; mosi_w[2] = 8'h33;
            run_frame($sformatf("c%0d_burst", c), 24);

            // Empty TX buffer.
            do_reset();
            mosi_w[0] = 8'hFF;
            run_frame($sformatf("c%0d_empty", c), 8);

            // Good frame, aborted frame after 5 bits, then a good frame again.
            do_reset();
            feed.push_back(8'($urandom)); feed.push_back(8'($urandom));
            mosi_w[0] = 8'($urandom);
            run_frame($sformatf("c%0d_pre", c), 8);
            mosi_w[0] = 8'($urandom);
            run_frame($sformatf("c%0d_abort", c), 5);
            feed.push_back(8'($urandom)); feed.push_back(8'($urandom));
            mosi_w[0] = 8'($urandom);
            run_frame($sformatf("c%0d_post", c), 8);

            // Random frames without reset in between.
            for (int r = 0; r < 6; r++) begin
                int kind = $urandom_range(0, 3);
                int nb   = (kind == 3) ? $urandom_range(1, 23) : 8 * (kind + 1);
                int nf   = $urandom_range(0, 3);
                for (int w = 0; w < nf; w++) feed.push_back(8'($urandom));
                for (int j = 0; j < 4; j++) mosi_w[j] = 8'($urandom);
                run_frame($sformatf("c%0d_rnd%0d", c, r), nb);
            end

            // Reset mid-word, then a clean frame.
            do_reset();
            feed.push_back(8'($urandom));
            mosi_w[0] = 8'($urandom);
            rx_cnt = 0; und_cnt = 0; abort_cnt = 0;
            t = $sformatf("c%0d_midrst", c);
            spi_frame(t, 4, 1'b0);
            rst_n      = 1'b0;
            acc_pend   = 1'b0;
            tx_valid_a = '0;
            wait_t(2);
            check_reset(t);
            ss_n_a[sel] = 1'b1;
            wait_t(2);
            chk({t, "_rx_cnt"}, rx_cnt,    0);
            chk({t, "_abort"},  abort_cnt, 0);
            feed.delete();
            feed_rd   = 0;
            model_ptr = 0;
            exp_rx    = '0;
            rst_n     = 1'b1;
            wait_t(2 * H);
            feed.push_back(8'($urandom));
            mosi_w[0] = 8'($urandom);
            run_frame($sformatf("c%0d_after", c), 8);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
